// File: rtl/neuron_mac_unit_pkg.sv
// Shared definitions for the neuron datapath and its control unit:
// state encodings, default widths and drain timing.
package neuron_mac_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FRAC_W     = 4;
    localparam int DEF_ACC_W      = 20;
    localparam int DEF_NUM_INPUTS = 4;
    localparam int DEF_LEAK_SHIFT = 1;

    // Two drain cycles: one for the product register, one for the accumulate.
    localparam logic DRAIN_LAST = 1'b1;

endpackage

// File: rtl/neuron_mac_unit_if.sv
// Operand stream in, activated neuron result out.
interface neuron_mac_unit_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_weight;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_weight,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_weight,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mac_saturating_add.sv
// Signed W-bit add that clips to the representable range and flags clipping.
module mac_saturating_add #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_o
);
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] wide_s;

    assign wide_s = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    // Disagreement of the two top bits means the true sum left the W-bit range.
    always_comb begin
        sat_o = wide_s[W] ^ wide_s[W-1];
        sum_o = wide_s[W-1:0];
        if (sat_o) begin
            sum_o = wide_s[W] ? MIN_V : MAX_V;
        end else begin
            sum_o = wide_s[W-1:0];
        end
    end
endmodule

// File: rtl/neuron_mac_unit.sv
// Neuron datapath: NUM_INPUTS multiply-accumulates through a two-stage pipe,
// optional leak on forget, then one ReLU-activated fixed-point result.
module neuron_mac_unit
    import neuron_mac_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              alu_rst_i,
    input  logic              alu_forget_i,
    neuron_mac_unit_if.slave  bus_if,
    output logic              busy_o,
    output logic              overflow_o
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
    localparam logic signed [DATA_W-1:0] ACT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     drain_q, drain_d;
    logic signed [PROD_W-1:0] prod_q, prod_d, prod_s;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  acc_base_s, addend_s, sum_s, scaled_s;
    logic                     sat_s;
    logic                     overflow_q, overflow_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d, act_s;
    logic                     in_ready_s, accept_s, last_pair_s, forget_s;

    assign in_ready_s  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign accept_s    = bus_if.in_valid && in_ready_s;
    assign last_pair_s = accept_s && (count_q == CNT_W'(NUM_INPUTS - 1));
    assign forget_s    = alu_forget_i && (state_q != ST_DONE);

    assign prod_s     = PROD_W'(bus_if.in_data) * PROD_W'(bus_if.in_weight);
    assign acc_base_s = forget_s ? (acc_q >>> LEAK_SHIFT) : acc_q;
    assign addend_s   = prod_vld_q ? ACC_W'(prod_q) : {ACC_W{1'b0}};

    mac_saturating_add #(.W(ACC_W)) u_sat_add (
        .a_i   (acc_base_s),
        .b_i   (addend_s),
        .sum_o (sum_s),
        .sat_o (sat_s)
    );

    // Fixed-point rescale, clip to the output width and ReLU.
    always_comb begin
        scaled_s = acc_q >>> FRAC_W;
        act_s    = {DATA_W{1'b0}};
        if (scaled_s[ACC_W-1]) begin
            act_s = {DATA_W{1'b0}};
        end else if (scaled_s > ACC_W'(ACT_MAX)) begin
            act_s = ACT_MAX;
        end else begin
            act_s = scaled_s[DATA_W-1:0];
        end
    end

    // Next-state, pipe and accumulator update; alu_rst overrides everything.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        drain_d     = drain_q;
        prod_d      = accept_s ? prod_s : prod_q;
        prod_vld_d  = accept_s;
        acc_d       = sum_s;
        overflow_d  = overflow_q | (prod_vld_q & sat_s);
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    count_d = count_q + CNT_W'(1);
                    drain_d = 1'b0;
                    if (last_pair_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d     = ST_DONE;
                    drain_d     = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = act_s;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                acc_d      = {ACC_W{1'b0}};
                count_d    = {CNT_W{1'b0}};
                overflow_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (alu_rst_i) begin
            state_d     = ST_IDLE;
            count_d     = {CNT_W{1'b0}};
            drain_d     = 1'b0;
            prod_d      = {PROD_W{1'b0}};
            prod_vld_d  = 1'b0;
            acc_d       = {ACC_W{1'b0}};
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = {DATA_W{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // State, pipe and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            count_q     <= {CNT_W{1'b0}};
            drain_q     <= 1'b0;
            prod_q      <= {PROD_W{1'b0}};
            prod_vld_q  <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus_if.in_ready  = in_ready_s;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign busy_o           = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign overflow_o       = overflow_q;
endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and
// compares them whenever out_valid is seen. Instance B uses ACC_W=16.
module tb_neuron_mac_unit;

    typedef struct {
        int data;
        int ov;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alu_rst_a = 1'b0, alu_forget_a = 1'b0;
    logic alu_rst_b = 1'b0, alu_forget_b = 1'b0;
    logic busy_a, ov_a, busy_b, ov_b;

    neuron_mac_unit_if #(.DATA_W(8)) ia ();
    neuron_mac_unit_if #(.DATA_W(8)) ib ();

    neuron_mac_unit u_dut_a (
        .clk_i        (clk),
        .reset_i      (reset),
        .alu_rst_i    (alu_rst_a),
        .alu_forget_i (alu_forget_a),
        .bus_if       (ia),
        .busy_o       (busy_a),
        .overflow_o   (ov_a)
    );

    neuron_mac_unit #(.ACC_W(16)) u_dut_b (
        .clk_i        (clk),
        .reset_i      (reset),
        .alu_rst_i    (alu_rst_b),
        .alu_forget_i (alu_forget_b),
        .bus_if       (ib),
        .busy_o       (busy_b),
        .overflow_o   (ov_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rdy(input int sel);
        return (sel == 0) ? int'(ia.in_ready) : int'(ib.in_ready);
    endfunction

    task automatic drive(input int sel, input bit v, input int d, input int w);
        if (sel == 0) begin
            ia.in_valid = v; ia.in_data = 8'(d); ia.in_weight = 8'(w);
        end else begin
            ib.in_valid = v; ib.in_data = 8'(d); ib.in_weight = 8'(w);
        end
    endtask

    // Offer n identical pairs back-to-back; expected result is due 3 cycles
    // after the cycle holding the last accepted pair.
    task automatic burst(input int sel, input int n, input int d, input int w,
                         input bit push, input int exp_d, input int exp_ov);
        exp_t e;
        int   t = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, d, w);
            #1;
            chk("accept_ready", rdy(sel), 1);
            t = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        drive(sel, 1'b0, 0, 0);
        if (push) begin
            e.data = exp_d; e.ov = exp_ov; e.cyc = t + 3;
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (rdy(sel) == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", rdy(sel), 1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ia.out_valid) begin
            pulses_a++;
            if (qa.size() == 0) chk("unexpected_out_a", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("out_data_a", int'(ia.out_data), ea.data);
                chk("overflow_a", int'(ov_a), ea.ov);
                chk("latency_a", cyc, ea.cyc);
            end
        end
        if (ib.out_valid) begin
            pulses_b++;
            if (qb.size() == 0) chk("unexpected_out_b", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("out_data_b", int'(ib.out_data), eb.data);
                chk("overflow_b", int'(ov_b), eb.ov);
                chk("latency_b", cyc, eb.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready_a", int'(ia.in_ready), 1);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_out_valid_a", int'(ia.out_valid), 0);
        chk("rst_out_data_a", int'(ia.out_data), 0);
        chk("rst_overflow_a", int'(ov_a), 0);
        chk("rst_in_ready_b", int'(ib.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // 1.0*1.0 x4 -> 4.0, and in_ready low for DRAIN, DRAIN, DONE
        burst(0, 4, 16, 16, 1'b1, 64, 0);
        chk("busy_in_drain", int'(busy_a), 1);
        n = 0;
        while (ia.in_ready == 1'b0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", n, 3);
        wait_idle(0);

        // negative sum -> ReLU clamps to zero, pulse still issued
        burst(0, 4, 16, -16, 1'b1, 0, 0);
        wait_idle(0);

        // ACC_W=16: 127*127 x4 clips at 32767 -> out 127, overflow set
        burst(1, 4, 127, 127, 1'b1, 127, 1);
        wait_idle(1);
        chk("overflow_cleared_b", int'(ov_b), 0);
        burst(1, 4, 16, 16, 1'b1, 64, 0);
        wait_idle(1);

        // 512 -> forget -> 256, then +512 -> 768 -> 48
        burst(0, 2, 16, 16, 1'b0, 0, 0);
        @(negedge clk);
        alu_forget_a = 1'b1;
        @(negedge clk);
        alu_forget_a = 1'b0;
        burst(0, 2, 16, 16, 1'b1, 48, 0);
        wait_idle(0);

        // alu_rst mid-evaluation discards the partial sum and count
        burst(0, 2, 16, 16, 1'b0, 0, 0);
        alu_rst_a = 1'b1;
        @(negedge clk);
        alu_rst_a = 1'b0;
        chk("alu_rst_ready", int'(ia.in_ready), 1);
        chk("alu_rst_busy", int'(busy_a), 0);
        burst(0, 4, 16, 16, 1'b1, 64, 0);
        wait_idle(0);

        // async reset during DRAIN: no result, pairs offered in DRAIN refused
        burst(0, 4, 16, 16, 1'b0, 0, 0);
        drive(0, 1'b1, 16, 16);
        #1;
        chk("drain_refuse_1", int'(ia.in_ready), 0);
        @(negedge clk);
        #1;
        chk("drain_refuse_2", int'(ia.in_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ready", int'(ia.in_ready), 1);
        chk("async_rst_busy", int'(busy_a), 0);
        chk("async_rst_out_valid", int'(ia.out_valid), 0);
        chk("async_rst_out_data", int'(ia.out_data), 0);
        chk("async_rst_overflow", int'(ov_a), 0);
        drive(0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        repeat (10) @(negedge clk);
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        chk("pulses_a", pulses_a, 4);
        chk("pulses_b", pulses_b, 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
